// File: rtl/cmac_pkg.sv
// Constants shared by the CMAC array and its column drain.
// Also holds the saturating error-compensation adder.
package cmac_pkg;

  localparam int PSUM_W = 24;
  localparam int PROD_W = 16;
  localparam int ACT_W  = 8;

  typedef struct packed {
    logic              sat;
    logic [PSUM_W-1:0] sum;
  } sat_sum_t;

  function automatic sat_sum_t sat_add_psum(input logic [PSUM_W-1:0] psum,
                                            input logic [PROD_W-1:0] prod);
    logic [PSUM_W:0] wide;
    sat_sum_t        res;
    wide    = {1'b0, psum} + {{(PSUM_W + 1 - PROD_W){1'b0}}, prod};
    res.sat = wide[PSUM_W];
    res.sum = wide[PSUM_W] ? {PSUM_W{1'b1}} : wide[PSUM_W-1:0];
    return res;
  endfunction

endpackage

// File: rtl/cmac_column_drain_fifo.sv
// Synchronous result FIFO with wrap-bit pointers and a registered head
// entry; clear has priority over push and pop.
module drain_fifo #(
  parameter int W     = 24,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic [W-1:0]  head_q, head_d;
  logic [AW:0]   count_s;
  logic [AW-1:0] rd_nxt_idx_s;
  logic          push_s;
  logic          pop_s;

  assign empty        = (wr_ptr_q == rd_ptr_q);
  assign full         = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                        (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign count_s      = wr_ptr_q - rd_ptr_q;
  assign rd_nxt_idx_s = rd_ptr_q[AW-1:0] + AW'(1);
  assign pop_s        = pop && !empty && !clear;
  assign push_s       = push && (!full || pop_s) && !clear;
  assign rdata        = head_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    head_d   = head_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      head_d   = '0;
    end else begin
      if (push_s) begin
        wr_ptr_d = wr_ptr_q + (AW + 1)'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      // The head register tracks what the next entry at the read pointer will be.
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + (AW + 1)'(1);
        if (count_s > (AW + 1)'(1)) begin
          head_d = mem_q[rd_nxt_idx_s];
        end else if (push_s) begin
          head_d = wdata;
        end else begin
          head_d = '0;
        end
      end else if (push_s && empty) begin
        head_d = wdata;
      end else begin
        head_d = head_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      head_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      head_q   <= head_d;
      if (push_s) begin
        mem_q[wr_ptr_q[AW-1:0]] <= wdata;
      end
    end
  end

endmodule

// File: rtl/cmac_column_drain.sv
// Column drain: compensates the last stage's deferred error product, buffers
// corrected sums for the output writer and keeps low-voltage error status.
module cmac_column_drain #(
  parameter int PSUM_W = cmac_pkg::PSUM_W,
  parameter int PROD_W = cmac_pkg::PROD_W,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [PSUM_W-1:0] psum_in,
  input  logic [PROD_W-1:0] err_prod_in,
  input  logic              err_sig_in,
  input  logic              in_valid,
  input  logic              clear,
  output logic [PSUM_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              full,
  output logic              overflow,
  output logic              sat_flag,
  output logic [CNT_W-1:0]  err_count
);

  import cmac_pkg::*;

  sat_sum_t          corr_s;
  logic [PROD_W-1:0] prod_sel_s;
  logic              empty_s;
  logic              pop_s;
  logic              accept_s;
  logic              overflow_q, overflow_d;
  logic              sat_flag_q, sat_flag_d;
  logic [CNT_W-1:0]  err_count_q, err_count_d;

  assign prod_sel_s = err_sig_in ? err_prod_in : {PROD_W{1'b0}};
  assign corr_s     = sat_add_psum(psum_in, prod_sel_s);
  assign out_valid  = !empty_s;
  assign pop_s      = out_valid && out_ready;
  assign accept_s   = in_valid && (!full || pop_s) && !clear;

  drain_fifo #(
    .W     (PSUM_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .push  (accept_s),
    .pop   (pop_s),
    .wdata (corr_s.sum),
    .rdata (out_data),
    .full  (full),
    .empty (empty_s)
  );

  // Status only reflects beats that actually entered the FIFO.
  always_comb begin
    overflow_d  = overflow_q;
    sat_flag_d  = sat_flag_q;
    err_count_d = err_count_q;
    if (clear) begin
      overflow_d  = 1'b0;
      sat_flag_d  = 1'b0;
      err_count_d = '0;
    end else begin
      if (in_valid && !accept_s) begin
        overflow_d = 1'b1;
      end else begin
        overflow_d = overflow_q;
      end
      if (accept_s && corr_s.sat) begin
        sat_flag_d = 1'b1;
      end else begin
        sat_flag_d = sat_flag_q;
      end
      if (accept_s && err_sig_in && (err_count_q != {CNT_W{1'b1}})) begin
        err_count_d = err_count_q + CNT_W'(1);
      end else begin
        err_count_d = err_count_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_q  <= 1'b0;
      sat_flag_q  <= 1'b0;
      err_count_q <= '0;
    end else begin
      overflow_q  <= overflow_d;
      sat_flag_q  <= sat_flag_d;
      err_count_q <= err_count_d;
    end
  end

  assign overflow  = overflow_q;
  assign sat_flag  = sat_flag_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_cmac_column_drain.sv
// Directed bench for cmac_column_drain: a queue-based reference model checked
// on every falling edge, plus literal expectations from the test plan.
module tb_cmac_column_drain;

  logic        clk;
  logic        rst_n;
  logic [23:0] psum_in;
  logic [15:0] err_prod_in;
  logic        err_sig_in;
  logic        in_valid;
  logic        clear;
  logic [23:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        full;
  logic        overflow;
  logic        sat_flag;
  logic [15:0] err_count;

  int checks = 0;
  int errors = 0;

  logic [23:0] m_q[$];
  logic        m_ovf = 1'b0;
  logic        m_sat = 1'b0;
  int          m_cnt = 0;

  cmac_column_drain dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .psum_in     (psum_in),
    .err_prod_in (err_prod_in),
    .err_sig_in  (err_sig_in),
    .in_valid    (in_valid),
    .clear       (clear),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .full        (full),
    .overflow    (overflow),
    .sat_flag    (sat_flag),
    .err_count   (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: FIFO as a queue, status as plain counters.
  always @(posedge clk or negedge rst_n) begin
    logic [31:0] s;
    bit          do_pop;
    bit          do_acc;
    if (!rst_n || clear) begin
      m_q.delete();
      m_ovf = 1'b0;
      m_sat = 1'b0;
      m_cnt = 0;
    end else begin
      do_pop = (m_q.size() > 0) && out_ready;
      do_acc = in_valid && ((m_q.size() < 4) || do_pop);
      s = 32'(psum_in) + (err_sig_in ? 32'(err_prod_in) : 32'd0);
      if (do_pop) void'(m_q.pop_front());
      if (do_acc) begin
        m_q.push_back((s > 32'h00FF_FFFF) ? 24'hFF_FFFF : s[23:0]);
        if (s > 32'h00FF_FFFF) m_sat = 1'b1;
        if (err_sig_in && m_cnt < 65535) m_cnt++;
      end else if (in_valid) begin
        m_ovf = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    check("out_valid", 32'(out_valid), 32'(m_q.size() > 0));
    check("out_data",  32'(out_data),  (m_q.size() > 0) ? 32'(m_q[0]) : 32'd0);
    check("full",      32'(full),      32'(m_q.size() == 4));
    check("overflow",  32'(overflow),  32'(m_ovf));
    check("sat_flag",  32'(sat_flag),  32'(m_sat));
    check("err_count", 32'(err_count), 32'(m_cnt));
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic [23:0] p, input logic [15:0] e, input logic es,
                       input logic v, input logic r);
    psum_in     = p;
    err_prod_in = e;
    err_sig_in  = es;
    in_valid    = v;
    out_ready   = r;
    step();
  endtask

  initial begin
    rst_n = 1'b0; clear = 1'b0; psum_in = '0; err_prod_in = '0;
    err_sig_in = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    step(); step();
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_count", 32'(err_count), 32'd0);
    rst_n = 1'b1;
    step();

    // Compensation
    drive(24'h004000, 16'h0020, 1'b1, 1'b1, 1'b1);
    check("comp_valid", 32'(out_valid), 32'd1);
    check("comp_data",  32'(out_data),  32'h004020);
    check("comp_cnt",   32'(err_count), 32'd1);
    drive(24'h0, 16'h0, 1'b0, 1'b0, 1'b1);

    // No error: product ignored
    drive(24'h008000, 16'h0012, 1'b0, 1'b1, 1'b1);
    check("noerr_data", 32'(out_data),  32'h008000);
    check("noerr_cnt",  32'(err_count), 32'd1);

    // Saturation
    drive(24'hFFFFF0, 16'h0060, 1'b1, 1'b1, 1'b1);
    check("sat_data", 32'(out_data), 32'hFFFFFF);
    check("sat_flag", 32'(sat_flag), 32'd1);
    drive(24'h0, 16'h0, 1'b0, 1'b0, 1'b1);
    check("sat_sticky", 32'(sat_flag), 32'd1);

    // Backpressure: fifth beat dropped
    for (int i = 1; i <= 5; i++) begin
      drive(24'(i), 16'hFFFF, 1'b0, 1'b1, 1'b0);
      if (i == 4) check("bp_full", 32'(full), 32'd1);
    end
    check("bp_ovf", 32'(overflow), 32'd1);
    for (int i = 1; i <= 4; i++) begin
      check("bp_order", 32'(out_data), 32'(i));
      drive(24'h0, 16'h0, 1'b0, 1'b0, 1'b1);
    end
    check("bp_empty", 32'(out_valid), 32'd0);

    // Clear the sticky overflow, then full with push and pop together
    clear = 1'b1;
    step();
    clear = 1'b0;
    check("clr_ovf", 32'(overflow), 32'd0);
    for (int i = 0; i < 4; i++) drive(24'hB + 24'(i), 16'h0, 1'b0, 1'b1, 1'b0);
    drive(24'h00000A, 16'h0, 1'b0, 1'b1, 1'b1);
    check("pp_full", 32'(full),     32'd1);
    check("pp_head", 32'(out_data), 32'h00000C);
    check("pp_ovf",  32'(overflow), 32'd0);
    for (int i = 0; i < 5; i++) drive(24'h0, 16'h0, 1'b0, 1'b0, 1'b1);

    // Asynchronous reset with three queued beats
    for (int i = 0; i < 3; i++) drive(24'h100 + 24'(i), 16'h1, 1'b1, 1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(out_valid), 32'd0);
    check("arst_count", 32'(err_count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Clear with a beat presented: beat discarded and not counted
    for (int i = 0; i < 2; i++) drive(24'h200 + 24'(i), 16'h1, 1'b1, 1'b1, 1'b0);
    clear = 1'b1;
    drive(24'h000077, 16'h1, 1'b1, 1'b1, 1'b0);
    clear = 1'b0;
    check("clr_valid", 32'(out_valid), 32'd0);
    check("clr_count", 32'(err_count), 32'd0);
    drive(24'h0, 16'h0, 1'b0, 1'b0, 1'b1);
    check("clr_still_empty", 32'(out_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
